// File: rtl/add_share_ctrl.sv
// Arbitrates two requesters onto one shared fixed-latency adder.
// It sequences issue, wait and response, and reports per-request service time.
module add_share_ctrl #(
   parameter int ADD_LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [47:0] req_a,
   input  logic [47:0] req_b,
   input  logic [9:0]  req_mbit_a,
   input  logic [9:0]  req_mbit_b,
   output logic [23:0] add_a,
   output logic [23:0] add_b,
   output logic [4:0]  add_mbit_a,
   output logic [4:0]  add_mbit_b,
   output logic        add_start,
   input  logic        add_sign,
   input  logic [3:0]  add_exp,
   input  logic [18:0] add_man,
   input  logic [4:0]  add_mbit,
   input  logic [4:0]  add_bias,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [23:0] rsp_data,
   output logic [4:0]  rsp_mbit,
   output logic [4:0]  rsp_bias,
   output logic [18:0] rsp_cycles
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0]  LAT_LAST = 4'(ADD_LAT - 1);
   localparam logic [19:0] LAT_OVH  = 20'(ADD_LAT + 2);
   localparam logic [18:0] CNT_MAX  = '1;

   function automatic logic [4:0] clamp_mbit(input logic [4:0] m);
      return (m > 5'd19) ? 5'd19 : m;
   endfunction

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic [3:0]        lat_q, lat_d;
   logic [1:0][18:0]  wait_q, wait_d;
   logic              id_q, id_d;
   logic [23:0]       a_q, a_d, b_q, b_d;
   logic [4:0]        ma_q, ma_d, mb_q, mb_d;
   logic [18:0]       cyc_q, cyc_d;
   logic [23:0]       rsp_data_q, rsp_data_d;
   logic [4:0]        rsp_mbit_q, rsp_mbit_d;
   logic [4:0]        rsp_bias_q, rsp_bias_d;
   logic [18:0]       rsp_cycles_q, rsp_cycles_d;

   logic              gnt_id;
   logic [1:0]        hs;
   logic [18:0]       sel_wait;
   logic [19:0]       svc_sum;

   // Ready is gated by rst_n so it reads zero while reset is held.
   always_comb begin
      gnt_id = 1'b0;
      if (req_valid == 2'b11) begin
         gnt_id = ~last_q;
      end else if (req_valid[1]) begin
         gnt_id = 1'b1;
      end
      req_ready = 2'b00;
      if (rst_n && (state_q == IDLE) && (|req_valid)) begin
         req_ready = gnt_id ? 2'b10 : 2'b01;
      end
      hs = req_valid & req_ready;
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         wait_d[i] = wait_q[i];
         if (!req_valid[i] || hs[i]) begin
            wait_d[i] = '0;
         end else if (!req_ready[i] && (wait_q[i] != CNT_MAX)) begin
            wait_d[i] = wait_q[i] + 19'd1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      lat_d        = lat_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      ma_d         = ma_q;
      mb_d         = mb_q;
      cyc_d        = cyc_q;
      rsp_data_d   = rsp_data_q;
      rsp_mbit_d   = rsp_mbit_q;
      rsp_bias_d   = rsp_bias_q;
      rsp_cycles_d = rsp_cycles_q;
      sel_wait     = gnt_id ? wait_q[1] : wait_q[0];
      svc_sum      = {1'b0, sel_wait} + LAT_OVH;

      unique case (state_q)
         IDLE: begin
            if (|hs) begin
               state_d = ISSUE;
               id_d    = gnt_id;
               last_d  = gnt_id;
               a_d     = gnt_id ? req_a[47:24] : req_a[23:0];
               b_d     = gnt_id ? req_b[47:24] : req_b[23:0];
               ma_d    = clamp_mbit(gnt_id ? req_mbit_a[9:5] : req_mbit_a[4:0]);
               mb_d    = clamp_mbit(gnt_id ? req_mbit_b[9:5] : req_mbit_b[4:0]);
               cyc_d   = svc_sum[19] ? CNT_MAX : svc_sum[18:0];
            end
         end
         ISSUE: begin
            state_d = WAIT;
            lat_d   = LAT_LAST;
         end
         WAIT: begin
            // The adder result is only trusted on the edge closing the final wait cycle.
            if (lat_q == 4'd0) begin
               state_d      = RESP;
               rsp_data_d   = {add_sign, add_exp, add_man};
               rsp_mbit_d   = add_mbit;
               rsp_bias_d   = add_bias;
               rsp_cycles_d = cyc_q;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         lat_q        <= '0;
         wait_q       <= '0;
         id_q         <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         ma_q         <= '0;
         mb_q         <= '0;
         cyc_q        <= '0;
         rsp_data_q   <= '0;
         rsp_mbit_q   <= '0;
         rsp_bias_q   <= '0;
         rsp_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         lat_q        <= lat_d;
         wait_q       <= wait_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         ma_q         <= ma_d;
         mb_q         <= mb_d;
         cyc_q        <= cyc_d;
         rsp_data_q   <= rsp_data_d;
         rsp_mbit_q   <= rsp_mbit_d;
         rsp_bias_q   <= rsp_bias_d;
         rsp_cycles_q <= rsp_cycles_d;
      end
   end

   assign add_a      = a_q;
   assign add_b      = b_q;
   assign add_mbit_a = ma_q;
   assign add_mbit_b = mb_q;
   assign add_start  = (state_q == ISSUE);
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_mbit   = rsp_mbit_q;
   assign rsp_bias   = rsp_bias_q;
   assign rsp_cycles = rsp_cycles_q;

endmodule

// File: doc/add_share_ctrl.md
ADD_SHARE_CTRL -- requirements
Module: add_share_ctrl

Interface
REQ-001 SHALL have parameter ADD_LAT, default 3, meaning cycles from add_start to valid adder result (legal 1..15).
REQ-002 SHALL have ports, one clock, asynchronous active-low reset:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester operand valid
- req_ready  out  2  per-requester grant/accept
- req_a  in  48  operand A, requester i at [24i+23:24i], {sign, exp[3:0], frac[18:0]}
- req_b  in  48  operand B, same packing
- req_mbit_a  in  10  mantissa bit count of A, requester i at [5i+4:5i]
- req_mbit_b  in  10  mantissa bit count of B, same packing
- add_a, add_b  out  24  operands to shared adder
- add_mbit_a, add_mbit_b  out  5  mantissa bit counts to adder
- add_start  out  1  one-cycle launch strobe
- add_sign  in  1; add_exp  in  4; add_man  in  19; add_mbit  in  5; add_bias  in  5  adder result fields
- rsp_valid  out  1; rsp_ready  in  1  response handshake
- rsp_id  out  1  requester owning response
- rsp_data  out  24  {add_sign, add_exp, add_man}
- rsp_mbit  out  5; rsp_bias  out  5  captured adder fields
- rsp_cycles  out  19  total service time of this request

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-004 IDLE: req_ready asserted only for granted requester, only in IDLE, one-hot or zero; handshake = req_valid[i] & req_ready[i].
REQ-005 Grant: single valid requester wins; both valid -> requester not granted last (round-robin pointer, reset favours requester 0); pointer updates only on handshake.
REQ-006 On handshake SHALL capture operands, mbits, rsp_id; go ISSUE next cycle.
REQ-007 Mbit values > 19 SHALL be clamped to 19 on capture; others passed unchanged.
REQ-008 ISSUE: add_start = 1 for exactly one cycle; add_a/add_b/add_mbit_* held stable from ISSUE until leaving RESP.
REQ-009 WAIT: lasts exactly ADD_LAT cycles; adder result fields sampled on edge ending the last WAIT cycle into rsp_* registers.
REQ-010 RESP: rsp_valid = 1 with stable rsp_* until rsp_ready; on rsp_valid & rsp_ready return to IDLE; new grant no earlier than next cycle.
REQ-011 Per-requester 19-bit wait counter: increments each cycle req_valid[i] & !req_ready[i], saturates at 19'h7FFFF, clears when req_valid[i] low or on handshake.
REQ-012 rsp_cycles = captured wait count + ADD_LAT + 2, saturating at 19'h7FFFF; response back-pressure not counted.
REQ-013 Handshake at cycle T -> rsp_valid first high at T+ADD_LAT+2.
REQ-014 req_valid changes outside IDLE SHALL not disturb in-flight operation; adder inputs ignored outside the sampling edge.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE, pointer to favour requester 0, wait counters 0, and all outputs 0 (req_ready, add_*, rsp_*) including mid-operation; in-flight request discarded, no response.
REQ-016 First grant no earlier than first rising edge after rst_n deasserts.

Verification
REQ-017 Single request: req0 a=24'h380004 mbit_a=3, b=24'h380000 mbit_b=2, valid at T -> add_start at T+1, rsp_valid at T+5, rsp_id=0, rsp_data=adder output, rsp_cycles=5.
REQ-018 Contention: both valid from reset -> grants order 0,1,0,1; requester 1 first rsp_cycles = 5 + cycles waited (=6 with rsp_ready held high, i.e. 11).
REQ-019 Back-pressure: rsp_ready low 4 cycles -> rsp_* stable, req_ready stays 0, rsp_cycles unchanged (5).
REQ-020 Clamp: req_mbit_a=25 -> add_mbit_a=19; mbit 19 -> 19.
REQ-021 Reset mid-WAIT: rst_n low -> all outputs 0 immediately, no rsp_valid after release; next request served normally with rsp_cycles=5.
REQ-022 Saturation: req1 held valid while req0 monopolises (forced pointer) beyond 2^19 cycles, or counter preloaded -> rsp_cycles=19'h7FFFF.
